// File: rtl/led_share_arbiter.sv
// Round-robin arbiter that hands a shared 2-bit LED to one of four requesters,
// each driving its own pattern (off/solid/blink/alternate) for a minimum hold.

// First set request bit starting at ptr and wrapping upward.
module led_share_rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          vld,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] cand;

  always_comb begin
    vld  = |req;
    idx  = '0;
    cand = '0;
    // Walk from the farthest offset down so the closest hit to ptr wins.
    for (int k = N - 1; k >= 0; k--) begin
      cand = IW'((int'(ptr) + k) % N);
      if (req[cand]) idx = cand;
    end
  end
endmodule

module led_share_arbiter #(
  parameter int TICK_DIV   = 25_000_000,
  parameter int HOLD_TICKS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [7:0] mode,
  output logic [1:0] led,
  output logic [3:0] grant,
  output logic       busy
);
  localparam int NUM_REQ = 4;
  localparam int PTR_W   = $clog2(NUM_REQ);
  localparam int TICK_W  = $clog2(TICK_DIV);
  localparam int HOLD_W  = $clog2(HOLD_TICKS + 1);

  typedef enum logic {IDLE, SERVE} state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [PTR_W-1:0]    owner_q, owner_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [1:0]          led_q, led_d;
  logic [1:0]          mode_q, mode_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [TICK_W-1:0]   tcnt_q;
  logic                tick;
  logic                pick_vld;
  logic [PTR_W-1:0]    pick_idx;

  function automatic logic [1:0] pattern_load(input logic [1:0] m);
    case (m)
      2'b00:   pattern_load = 2'b00;
      2'b01:   pattern_load = 2'b11;
      2'b10:   pattern_load = 2'b11;
      default: pattern_load = 2'b10;
    endcase
  endfunction

  function automatic logic [1:0] pattern_step(input logic [1:0] m, input logic [1:0] l);
    case (m)
      2'b10:   pattern_step = ~l;
      2'b11:   pattern_step = {l[0], l[1]};
      default: pattern_step = l;
    endcase
  endfunction

  // Free-running tick divider, independent of arbitration state.
  assign tick = (tcnt_q == TICK_W'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tcnt_q <= '0;
    else if (tick) tcnt_q <= '0;
    else tcnt_q <= tcnt_q + TICK_W'(1);
  end

  led_share_rr_pick #(.N(NUM_REQ), .IW(PTR_W)) u_pick (
    .req (req),
    .ptr (ptr_q),
    .vld (pick_vld),
    .idx (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    grant_d = grant_q;
    led_d   = led_q;
    mode_d  = mode_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = SERVE;
          owner_d = pick_idx;
          grant_d = NUM_REQ'(1) << pick_idx;
          mode_d  = mode[{pick_idx, 1'b0} +: 2];
          led_d   = pattern_load(mode[{pick_idx, 1'b0} +: 2]);
          hold_d  = '0;
        end
      end
      SERVE: begin
        // Owner dropping its request beats any tick in the same cycle.
        if (!req[owner_q]) begin
          state_d = IDLE;
          grant_d = '0;
          led_d   = 2'b00;
          ptr_d   = owner_q + PTR_W'(1);
        end else if (tick) begin
          led_d = pattern_step(mode_q, led_q);
          if (hold_q == HOLD_W'(HOLD_TICKS - 1)) begin
            if (|(req & ~grant_q)) begin
              state_d = IDLE;
              grant_d = '0;
              led_d   = 2'b00;
              ptr_d   = owner_q + PTR_W'(1);
            end else begin
              hold_d = '0;
            end
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      grant_q <= '0;
      led_q   <= 2'b00;
      mode_q  <= 2'b00;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      led_q   <= led_d;
      mode_q  <= mode_d;
      hold_q  <= hold_d;
    end
  end

  assign led   = led_q;
  assign grant = grant_q;
  assign busy  = (state_q == SERVE);
endmodule

// File: tb/tb_led_share_arbiter.sv
// Randomized and directed bench for led_share_arbiter against an owner/ptr
// level model of the sharing rules (TICK_DIV=4, HOLD_TICKS=2).
module tb_led_share_arbiter;
  localparam int TD = 4;
  localparam int HT = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [7:0] mode;
  logic [1:0] led;
  logic [3:0] grant;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  int m_cnt, m_owner, m_ptr, m_hold, m_mode, m_led;

  always #5 clk = ~clk;

  led_share_arbiter #(.TICK_DIV(TD), .HOLD_TICKS(HT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .mode  (mode),
    .led   (led),
    .grant (grant),
    .busy  (busy)
  );

  task automatic model_reset();
    m_cnt = 0; m_owner = -1; m_ptr = 0; m_hold = 0; m_mode = 0; m_led = 0;
  endtask

  task automatic model_release();
    m_ptr   = (m_owner + 1) % 4;
    m_owner = -1;
    m_led   = 0;
  endtask

  task automatic model_step();
    bit tk;
    bit found;
    int i;
    tk    = (m_cnt == TD - 1);
    m_cnt = (m_cnt + 1) % TD;
    if (m_owner < 0) begin
      found = 0;
      for (int k = 0; k < 4; k++) begin
        i = (m_ptr + k) % 4;
        if (!found && req[i]) begin
          found   = 1;
          m_owner = i;
          m_mode  = (int'(mode) >> (2 * i)) & 3;
          m_led   = (m_mode == 0) ? 0 : (m_mode == 3) ? 2 : 3;
          m_hold  = 0;
        end
      end
    end else if (!req[m_owner]) begin
      model_release();
    end else if (tk) begin
      if (m_mode == 2) m_led = (m_led == 3) ? 0 : 3;
      else if (m_mode == 3) m_led = ((m_led & 1) << 1) | (m_led >> 1);
      m_hold++;
      if (m_hold == HT) begin
        if ((req & ~(4'b0001 << m_owner)) != 4'b0000) model_release();
        else m_hold = 0;
      end
    end
  endtask

  function automatic logic [6:0] exp_vec();
    logic [3:0] g;
    g = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    return {g, 2'(m_led), (m_owner >= 0)};
  endfunction

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    req = 4'b0000; mode = 8'h00;
    do_reset();
    n_cmp++;
    if (grant !== 4'b0000) begin n_bad++; $display("FAIL reset_grant got=%b want=0000", grant); end
    n_cmp++;
    if (led !== 2'b00) begin n_bad++; $display("FAIL reset_led got=%b want=00", led); end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    req = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({grant, led, busy} !== 7'b0) begin
      n_bad++; $display("FAIL reset_held got=%b want=0000000", {grant, led, busy});
    end
    req = 4'b0000;
    release_reset();
  endtask

  task automatic test_alternate();
    logic [1:0] prev;
    int toggles;
    do_reset();
    req = 4'b0001; mode = {6'($urandom), 2'b11};
    release_reset();
    step();
    n_cmp++;
    if (grant !== 4'b0001 || led !== 2'b10) begin
      n_bad++; $display("FAIL alt_first got grant=%b led=%b want grant=0001 led=10", grant, led);
    end
    prev = led; toggles = 0;
    for (int c = 0; c < 24; c++) begin
      step();
      if (led != prev) toggles++;
      prev = led;
      n_cmp++;
      if ({grant, led, busy} !== exp_vec()) begin
        n_bad++; $display("FAIL alt_cyc%0d got=%b want=%b", c, {grant, led, busy}, exp_vec());
      end
    end
    n_cmp++;
    if (toggles != 6 || grant !== 4'b0001) begin
      n_bad++; $display("FAIL alt_hold toggles=%0d grant=%b want toggles=6 grant=0001", toggles, grant);
    end
  endtask

  task automatic test_contention();
    do_reset();
    req = 4'b1010; mode = 8'($urandom);
    release_reset();
    for (int c = 1; c <= 12; c++) begin
      step();
      n_cmp++;
      if ({grant, led, busy} !== exp_vec()) begin
        n_bad++; $display("FAIL cont_cyc%0d got=%b want=%b", c, {grant, led, busy}, exp_vec());
      end
      if (c == 1 || c == 8 || c == 9) begin
        n_cmp++;
        if (grant !== ((c == 1) ? 4'b0010 : (c == 8) ? 4'b0000 : 4'b1000)) begin
          n_bad++; $display("FAIL cont_seq cyc%0d grant got=%b", c, grant);
        end
      end
    end
  endtask

  task automatic test_drop_on_tick();
    do_reset();
    req = 4'b0100; mode = 8'($urandom); mode[5:4] = 2'b10;
    release_reset();
    step();
    n_cmp++;
    if (grant !== 4'b0100 || led !== 2'b11) begin
      n_bad++; $display("FAIL drop_grant got grant=%b led=%b want 0100/11", grant, led);
    end
    step();
    step();
    req = 4'b0000;
    step();
    n_cmp++;
    if ({grant, led, busy} !== 7'b0) begin
      n_bad++; $display("FAIL drop_release got=%b want=0000000", {grant, led, busy});
    end
    req = 4'b1111;
    step();
    n_cmp++;
    if (grant !== 4'b1000) begin
      n_bad++; $display("FAIL drop_ptr grant got=%b want=1000", grant);
    end
    req = 4'b0000;
    step();
  endtask

  task automatic test_mode_change();
    do_reset();
    req = 4'b0001; mode = 8'b0000_0001;
    release_reset();
    step();
    mode[1:0] = 2'b11;
    for (int c = 0; c < 10; c++) begin
      step();
      n_cmp++;
      if (led !== 2'b11 || grant !== 4'b0001) begin
        n_bad++; $display("FAIL mode_latched cyc%0d got led=%b grant=%b want 11/0001", c, led, grant);
      end
    end
    req = 4'b0000;
    step();
    req = 4'b0001;
    step();
    n_cmp++;
    if (led !== 2'b10 || grant !== 4'b0001) begin
      n_bad++; $display("FAIL mode_regrant got led=%b grant=%b want 10/0001", led, grant);
    end
  endtask

  task automatic test_reset_mid_serve();
    do_reset();
    req = 4'b0100; mode = 8'b0001_0000;
    release_reset();
    step();
    n_cmp++;
    if (grant !== 4'b0100 || led !== 2'b11) begin
      n_bad++; $display("FAIL rst_mid_setup got grant=%b led=%b want 0100/11", grant, led);
    end
    req = 4'b0101;
    do_reset();
    n_cmp++;
    if ({grant, led, busy} !== 7'b0) begin
      n_bad++; $display("FAIL rst_mid_async got=%b want=0000000", {grant, led, busy});
    end
    release_reset();
    step();
    n_cmp++;
    if (grant !== 4'b0001) begin
      n_bad++; $display("FAIL rst_mid_regrant got=%b want=0001", grant);
    end
  endtask

  task automatic test_random();
    do_reset();
    req = 4'($urandom); mode = 8'($urandom);
    release_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(7) == 0) req = 4'($urandom);
      if ($urandom_range(15) == 0) mode = 8'($urandom);
      if ($urandom_range(499) == 0) begin
        do_reset();
        n_cmp++;
        if ({grant, led, busy} !== 7'b0) begin
          n_bad++; $display("FAIL rand_reset cyc%0d got=%b want=0000000", c, {grant, led, busy});
        end
        release_reset();
      end
      step();
      n_cmp++;
      if ({grant, led, busy} !== exp_vec()) begin
        n_bad++; $display("FAIL rand_cyc%0d req=%b got=%b want=%b", c, req, {grant, led, busy}, exp_vec());
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; req = 4'b0000; mode = 8'h00;
    model_reset();
    test_reset();
    test_alternate();
    test_contention();
    test_drop_on_tick();
    test_mode_change();
    test_reset_mid_serve();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
